// File: rtl/wid_elastic_pipe.sv
// Elastic register pipeline for wide words: DEPTH valid/ready stages with bubble
// collapse, synchronous flush and a registered occupancy count.
module wid_elastic_pipe #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] dat_p [DEPTH];
  logic [DEPTH-1:0] acc;
  logic             in_fire;
  logic             out_fire;

  // Stage i accepts when it or any stage downstream of it is empty, or the
  // output drains; written flat so the ready chain has no self-referencing net.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      acc[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!vld_p[j]) acc[i] = 1'b1;
      end
    end
  end

  assign in_ready  = acc[0] & ~flush & rst_n;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = vld_p[DEPTH-1] & out_ready;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = dat_p[DEPTH-1];

  // ---- control: valid bits and occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      count <= '0;
    end else if (flush) begin
      vld_p <= '0;
      count <= '0;
    end else begin
      if (acc[0]) vld_p[0] <= in_fire;
      for (int i = 1; i < DEPTH; i++) begin
        if (acc[i]) vld_p[i] <= vld_p[i-1];
      end
      count <= count + CW'(in_fire) - CW'(out_fire);
    end
  end

  // ---- data: registers move only with a valid word, frozen during flush ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dat_p[i] <= '0;
    end else if (!flush) begin
      if (in_fire) dat_p[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (acc[i] && vld_p[i-1]) dat_p[i] <= dat_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_wid_elastic_pipe.sv
// Randomized bench for wid_elastic_pipe against a queue-of-words model where each
// word carries its stage position and advances one stage per cycle when room exists.
module tb_wid_elastic_pipe;
  localparam int W = 512;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  wid_elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  int           mp[$];
  logic [W-1:0] last_end = '0;
  logic [W-1:0] src[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA5A5_0000 + n;
    return {16{w}};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step(output bit fired);
    bit ir, ov, outf;
    int lim, np;
    @(negedge clk);
    ir = !flush && (mq.size() < D || out_ready);
    ov = (mq.size() > 0) && (mp[0] == D - 1);
    check("in_ready", W'(in_ready), W'(ir));
    check("out_valid", W'(out_valid), W'(ov));
    check("count", W'(count), W'(mq.size()));
    check("out_data", out_data, last_end);
    fired = in_valid && ir;
    outf = ov && out_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      mp.delete();
    end else begin
      if (outf) begin
        void'(mq.pop_front());
        void'(mp.pop_front());
      end
      lim = D;
      foreach (mp[k]) begin
        np = (mp[k] + 1 < lim - 1) ? mp[k] + 1 : lim - 1;
        mp[k] = np;
        lim = np;
      end
      if (fired) begin
        mq.push_back(in_data);
        mp.push_back(0);
      end
      if (mq.size() > 0 && mp[0] == D - 1) last_end = mq[0];
    end
    #1;
  endtask

  task automatic cyc(input bit want, input bit ordy, input bit fl);
    bit fired;
    in_valid  = want && (src.size() > 0);
    in_data   = (src.size() > 0) ? src[0] : rnd_word();
    out_ready = ordy;
    flush     = fl;
    step(fired);
    if (fired) void'(src.pop_front());
  endtask

  initial begin
    // reset held with a producer already asserting valid
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = pat(99);
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data", out_data, '0);
      check("rst_count", W'(count), W'(0));
      check("rst_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // streaming
    for (int n = 0; n < 10; n++) src.push_back(pat(n));
    repeat (12) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // backpressure then release
    for (int n = 0; n < 5; n++) src.push_back(pat(20 + n));
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b1, 1'b0);

    // bubble collapse
    src.push_back(pat(40));
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    src.push_back(pat(41));
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // flush of a full pipe with valid asserted
    for (int n = 0; n < 4; n++) src.push_back(pat(50 + n));
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0);

    // asynchronous reset between edges with two words held
    src.push_back(pat(60));
    src.push_back(pat(61));
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_count", W'(count), W'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_count", W'(count), W'(0));
    check("arst_out_data", out_data, '0);
    check("arst_in_ready", W'(in_ready), W'(0));
    mq.delete();
    mp.delete();
    src.delete();
    last_end = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      if (src.size() < 3) src.push_back(rnd_word());
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    repeat (5) cyc(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
